// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detector: stalls EX while a load feeding one of its operands is
// still in DM1..DM3, freezes the whole pipeline on a data-cache miss, and counts stall cycles.
module load_use_hazard_unit #(
  parameter int unsigned                   REG_ADD_WIDTH        = 5,
  parameter int unsigned                   D_CACHE_LW_WIDTH     = 3,
  parameter logic [D_CACHE_LW_WIDTH-1:0]   DATA_CACHE_LOAD_NONE = '0,
  parameter int unsigned                   CNT_WIDTH            = 2,
  parameter int unsigned                   PERF_WIDTH           = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [REG_ADD_WIDTH-1:0]    RS1_ADDRESS_EXECUTION,
  input  logic                        RS1_USED_EXECUTION,
  input  logic [REG_ADD_WIDTH-1:0]    RS2_ADDRESS_EXECUTION,
  input  logic                        RS2_USED_EXECUTION,
  input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_DM1,
  input  logic                        RD_WRITE_ENABLE_DM1,
  input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_DM1,
  input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_DM2,
  input  logic                        RD_WRITE_ENABLE_DM2,
  input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_DM2,
  input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_DM3,
  input  logic                        RD_WRITE_ENABLE_DM3,
  input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_DM3,
  input  logic                        DATA_CACHE_READY,
  output logic                        STALL_FETCH_STAGE,
  output logic                        STALL_DECODE_STAGE,
  output logic                        STALL_EXECUTION_STAGE,
  output logic                        STALL_MEMORY_STAGES,
  output logic                        BUBBLE_DM1,
  output logic [1:0]                  HAZARD_STAGE,
  output logic [PERF_WIDTH-1:0]       LOAD_STALL_COUNT
);

  typedef enum logic {
    S_IDLE,
    S_LOAD_WAIT
  } state_t;

  state_t                  r_state;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [1:0]              r_held_stage;
  logic [1:0]              r_last_stage;
  logic [PERF_WIDTH-1:0]   r_load_stall_count;

  logic [2:0]              w_rs1_hit;
  logic [2:0]              w_rs2_hit;
  logic [2:0]              w_is_load;
  logic [1:0]              w_rs1_stage;
  logic [1:0]              w_rs2_stage;
  logic [1:0]              w_hz_stage;
  logic                    w_hazard;
  logic                    w_load_stall;
  logic [1:0]              w_hs_out;

  function automatic logic reg_match(
    input logic [REG_ADD_WIDTH-1:0] rs,
    input logic                     used,
    input logic [REG_ADD_WIDTH-1:0] rd,
    input logic                     we
  );
    return used && (rs != '0) && (rs == rd) && we;
  endfunction

  // The youngest writer decides: a non-load in a younger stage hides an older load.
  function automatic logic [1:0] load_producer(
    input logic [2:0] hit,
    input logic [2:0] is_load
  );
    if (hit[0]) return is_load[0] ? 2'd1 : 2'd0;
    if (hit[1]) return is_load[1] ? 2'd2 : 2'd0;
    if (hit[2]) return is_load[2] ? 2'd3 : 2'd0;
    return 2'd0;
  endfunction

  always_comb begin
    w_rs1_hit = {
      reg_match(RS1_ADDRESS_EXECUTION, RS1_USED_EXECUTION, RD_ADDRESS_DM3, RD_WRITE_ENABLE_DM3),
      reg_match(RS1_ADDRESS_EXECUTION, RS1_USED_EXECUTION, RD_ADDRESS_DM2, RD_WRITE_ENABLE_DM2),
      reg_match(RS1_ADDRESS_EXECUTION, RS1_USED_EXECUTION, RD_ADDRESS_DM1, RD_WRITE_ENABLE_DM1)
    };
    w_rs2_hit = {
      reg_match(RS2_ADDRESS_EXECUTION, RS2_USED_EXECUTION, RD_ADDRESS_DM3, RD_WRITE_ENABLE_DM3),
      reg_match(RS2_ADDRESS_EXECUTION, RS2_USED_EXECUTION, RD_ADDRESS_DM2, RD_WRITE_ENABLE_DM2),
      reg_match(RS2_ADDRESS_EXECUTION, RS2_USED_EXECUTION, RD_ADDRESS_DM1, RD_WRITE_ENABLE_DM1)
    };
    w_is_load = {
      DATA_CACHE_LOAD_DM3 != DATA_CACHE_LOAD_NONE,
      DATA_CACHE_LOAD_DM2 != DATA_CACHE_LOAD_NONE,
      DATA_CACHE_LOAD_DM1 != DATA_CACHE_LOAD_NONE
    };
    w_rs1_stage = load_producer(w_rs1_hit, w_is_load);
    w_rs2_stage = load_producer(w_rs2_hit, w_is_load);
    if (w_rs1_stage != 2'd0 && (w_rs2_stage == 2'd0 || w_rs1_stage <= w_rs2_stage)) begin
      w_hz_stage = w_rs1_stage;
    end else begin
      w_hz_stage = w_rs2_stage;
    end
    w_hazard     = (w_hz_stage != 2'd0);
    w_load_stall = (r_state == S_LOAD_WAIT) || w_hazard;
  end

  always_comb begin
    if (!DATA_CACHE_READY) begin
      w_hs_out = r_last_stage;
    end else if (r_state == S_LOAD_WAIT) begin
      w_hs_out = r_held_stage;
    end else begin
      w_hs_out = w_hz_stage;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state            <= S_IDLE;
      r_cnt              <= '0;
      r_held_stage       <= '0;
      r_last_stage       <= '0;
      r_load_stall_count <= '0;
    end else begin
      r_last_stage <= w_hs_out;
      if (DATA_CACHE_READY) begin
        if (w_load_stall) begin
          r_load_stall_count <= r_load_stall_count + PERF_WIDTH'(1);
        end
        case (r_state)
          S_IDLE: begin
            // A DM3 load needs only the detection cycle, so no wait state.
            if (w_hazard && w_hz_stage != 2'd3) begin
              r_state      <= S_LOAD_WAIT;
              r_cnt        <= CNT_WIDTH'(2'd3 - w_hz_stage);
              r_held_stage <= w_hz_stage;
            end
          end
          S_LOAD_WAIT: begin
            if (r_cnt == CNT_WIDTH'(1)) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt - CNT_WIDTH'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    STALL_FETCH_STAGE     = 1'b0;
    STALL_DECODE_STAGE    = 1'b0;
    STALL_EXECUTION_STAGE = 1'b0;
    STALL_MEMORY_STAGES   = 1'b0;
    BUBBLE_DM1            = 1'b0;
    HAZARD_STAGE          = 2'd0;
    LOAD_STALL_COUNT      = '0;
    if (!RST) begin
      HAZARD_STAGE     = w_hs_out;
      LOAD_STALL_COUNT = r_load_stall_count;
      if (!DATA_CACHE_READY) begin
        STALL_FETCH_STAGE     = 1'b1;
        STALL_DECODE_STAGE    = 1'b1;
        STALL_EXECUTION_STAGE = 1'b1;
        STALL_MEMORY_STAGES   = 1'b1;
      end else if (w_load_stall) begin
        STALL_FETCH_STAGE     = 1'b1;
        STALL_DECODE_STAGE    = 1'b1;
        STALL_EXECUTION_STAGE = 1'b1;
        BUBBLE_DM1            = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Directed bench for load_use_hazard_unit: a stall-cycle-budget model checked every cycle,
// plus literal expectations from hand-traced scenarios; a 2-bit-counter instance checks wrap.
module tb_load_use_hazard_unit;

  logic       CLK = 1'b0;
  logic       t_rst;
  logic [4:0] t_rs1, t_rs2;
  logic       t_rs1_used, t_rs2_used;
  logic [4:0] t_rd [1:3];
  logic       t_we [1:3];
  logic [2:0] t_ld [1:3];
  logic       t_ready;

  logic        o_sf, o_sd, o_se, o_sm, o_bub;
  logic [1:0]  o_hs;
  logic [31:0] o_cnt;
  logic        o2_sf, o2_sd, o2_se, o2_sm, o2_bub;
  logic [1:0]  o2_hs;
  logic [1:0]  o2_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model state: stall cycles still owed after the current one, held/last stage, counter.
  int          m_rem;
  logic [1:0]  m_held, m_last;
  logic [31:0] m_count;

  always #5 CLK = ~CLK;

  load_use_hazard_unit u_dut (
    .CLK(CLK), .RST(t_rst),
    .RS1_ADDRESS_EXECUTION(t_rs1), .RS1_USED_EXECUTION(t_rs1_used),
    .RS2_ADDRESS_EXECUTION(t_rs2), .RS2_USED_EXECUTION(t_rs2_used),
    .RD_ADDRESS_DM1(t_rd[1]), .RD_WRITE_ENABLE_DM1(t_we[1]), .DATA_CACHE_LOAD_DM1(t_ld[1]),
    .RD_ADDRESS_DM2(t_rd[2]), .RD_WRITE_ENABLE_DM2(t_we[2]), .DATA_CACHE_LOAD_DM2(t_ld[2]),
    .RD_ADDRESS_DM3(t_rd[3]), .RD_WRITE_ENABLE_DM3(t_we[3]), .DATA_CACHE_LOAD_DM3(t_ld[3]),
    .DATA_CACHE_READY(t_ready),
    .STALL_FETCH_STAGE(o_sf), .STALL_DECODE_STAGE(o_sd), .STALL_EXECUTION_STAGE(o_se),
    .STALL_MEMORY_STAGES(o_sm), .BUBBLE_DM1(o_bub), .HAZARD_STAGE(o_hs),
    .LOAD_STALL_COUNT(o_cnt)
  );

  load_use_hazard_unit #(.PERF_WIDTH(2)) u_dut_w2 (
    .CLK(CLK), .RST(t_rst),
    .RS1_ADDRESS_EXECUTION(t_rs1), .RS1_USED_EXECUTION(t_rs1_used),
    .RS2_ADDRESS_EXECUTION(t_rs2), .RS2_USED_EXECUTION(t_rs2_used),
    .RD_ADDRESS_DM1(t_rd[1]), .RD_WRITE_ENABLE_DM1(t_we[1]), .DATA_CACHE_LOAD_DM1(t_ld[1]),
    .RD_ADDRESS_DM2(t_rd[2]), .RD_WRITE_ENABLE_DM2(t_we[2]), .DATA_CACHE_LOAD_DM2(t_ld[2]),
    .RD_ADDRESS_DM3(t_rd[3]), .RD_WRITE_ENABLE_DM3(t_we[3]), .DATA_CACHE_LOAD_DM3(t_ld[3]),
    .DATA_CACHE_READY(t_ready),
    .STALL_FETCH_STAGE(o2_sf), .STALL_DECODE_STAGE(o2_sd), .STALL_EXECUTION_STAGE(o2_se),
    .STALL_MEMORY_STAGES(o2_sm), .BUBBLE_DM1(o2_bub), .HAZARD_STAGE(o2_hs),
    .LOAD_STALL_COUNT(o2_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stage (1..3) of the load feeding this operand, 0 if none or hidden by a younger writer.
  function automatic int load_stage(input logic [4:0] rs, input logic used);
    for (int k = 1; k <= 3; k++) begin
      if (used && rs != 5'd0 && t_we[k] && t_rd[k] == rs) return (t_ld[k] != 3'd0) ? k : 0;
    end
    return 0;
  endfunction

  task automatic model_check();
    int   s1, s2, hz;
    logic e_stall, e_mem, e_bub;
    logic [1:0]  e_hs;
    logic [31:0] e_cnt;
    s1 = load_stage(t_rs1, t_rs1_used);
    s2 = load_stage(t_rs2, t_rs2_used);
    hz = (s1 != 0 && (s2 == 0 || s1 < s2)) ? s1 : s2;
    if (t_rst) begin
      e_stall = 0; e_mem = 0; e_bub = 0; e_hs = 0; e_cnt = 0;
      m_rem = 0; m_count = 0; m_last = 0; m_held = 0;
    end else if (!t_ready) begin
      e_stall = 1; e_mem = 1; e_bub = 0; e_hs = m_last; e_cnt = m_count;
    end else begin
      e_stall = (m_rem > 0) || (hz != 0);
      e_mem = 0; e_bub = e_stall;
      e_hs = (m_rem > 0) ? m_held : 2'(hz);
      e_cnt = m_count;
      if (m_rem > 0) m_rem--;
      else if (hz != 0) begin m_rem = 3 - hz; m_held = 2'(hz); end
      if (e_stall) m_count++;
      m_last = e_hs;
    end
    chk("stall_fetch", 32'(o_sf), 32'(e_stall));
    chk("stall_decode", 32'(o_sd), 32'(e_stall));
    chk("stall_exec", 32'(o_se), 32'(e_stall));
    chk("stall_mem", 32'(o_sm), 32'(e_mem));
    chk("bubble_dm1", 32'(o_bub), 32'(e_bub));
    chk("hazard_stage", 32'(o_hs), 32'(e_hs));
    chk("stall_count", o_cnt, e_cnt);
    chk("stall_exec_w2", 32'(o2_se), 32'(e_stall));
    chk("stall_count_w2", 32'(o2_cnt), 32'(e_cnt[1:0]));
  endtask

  task automatic step();
    @(negedge CLK);
    model_check();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_all();
    t_rs1 = 0; t_rs2 = 0; t_rs1_used = 0; t_rs2_used = 0;
    for (int k = 1; k <= 3; k++) begin t_rd[k] = 0; t_we[k] = 0; t_ld[k] = 0; end
  endtask

  task automatic set_dm(input int k, input logic [4:0] rd, input logic [2:0] ld);
    t_rd[k] = rd; t_we[k] = 1'b1; t_ld[k] = ld;
  endtask

  task automatic clr_dm(input int k);
    t_rd[k] = 0; t_we[k] = 0; t_ld[k] = 0;
  endtask

  task automatic do_reset();
    t_rst = 1; t_ready = 1; clear_all();
    step();
    t_rst = 0;
  endtask

  initial begin
    m_rem = 0; m_held = 0; m_last = 0; m_count = 0;
    do_reset();
    #1 chk("reset_exec", 32'(o_se), 32'd0);
    chk("reset_count", o_cnt, 32'd0);

    // rs1 load in DM1: three stall cycles with bubbles.
    t_rs1 = 5; t_rs1_used = 1; set_dm(1, 5, 3'b010);
    #1 chk("t1_c0_hs", 32'(o_hs), 32'd1);
    chk("t1_c0_bub", 32'(o_bub), 32'd1);
    step();
    clr_dm(1); set_dm(2, 5, 3'b010); step();
    clr_dm(2); set_dm(3, 5, 3'b010);
    #1 chk("t1_c2_exec", 32'(o_se), 32'd1);
    chk("t1_c2_hs", 32'(o_hs), 32'd1);
    step();
    clr_dm(3);
    #1 chk("t1_c3_exec", 32'(o_se), 32'd0);
    chk("t1_c3_count", o_cnt, 32'd3);
    step();

    // Masking, x0 and unused operand: no stall.
    clear_all(); t_rs2 = 5; t_rs2_used = 1; set_dm(1, 5, 3'b000); set_dm(2, 5, 3'b010);
    #1 chk("mask_exec", 32'(o_se), 32'd0);
    step();
    clear_all(); t_rs1 = 0; t_rs1_used = 1; set_dm(1, 0, 3'b010);
    #1 chk("x0_exec", 32'(o_se), 32'd0);
    step();
    clear_all(); t_rs1 = 7; t_rs1_used = 0; set_dm(1, 7, 3'b010);
    #1 chk("unused_exec", 32'(o_se), 32'd0);
    step();

    // Two loads: rs1 in DM2, rs2 in DM3 -> two cycles, stage 2.
    do_reset();
    t_rs1 = 3; t_rs1_used = 1; t_rs2 = 4; t_rs2_used = 1;
    set_dm(2, 3, 3'b010); set_dm(3, 4, 3'b010);
    #1 chk("two_c0_hs", 32'(o_hs), 32'd2);
    step();
    clr_dm(2); set_dm(3, 3, 3'b010);
    #1 chk("two_c1_hs", 32'(o_hs), 32'd2);
    step();
    clr_dm(3);
    #1 chk("two_c2_exec", 32'(o_se), 32'd0);
    chk("two_c2_count", o_cnt, 32'd2);
    step();

    // Swapped: rs1 in DM3, rs2 in DM1 -> three cycles, stage 1.
    do_reset();
    t_rs1 = 3; t_rs1_used = 1; t_rs2 = 4; t_rs2_used = 1;
    set_dm(1, 4, 3'b100); set_dm(3, 3, 3'b010);
    #1 chk("swap_c0_hs", 32'(o_hs), 32'd1);
    step();
    clr_dm(1); clr_dm(3); set_dm(2, 4, 3'b100); step();
    clr_dm(2); set_dm(3, 4, 3'b100);
    #1 chk("swap_c2_exec", 32'(o_se), 32'd1);
    step();
    clr_dm(3);
    #1 chk("swap_c3_exec", 32'(o_se), 32'd0);
    chk("swap_c3_count", o_cnt, 32'd3);
    step();

    // Cache miss for two cycles inside LOAD_WAIT.
    do_reset();
    t_rs1 = 5; t_rs1_used = 1; set_dm(1, 5, 3'b010); step();
    t_ready = 0;
    #1 chk("miss_c1_mem", 32'(o_sm), 32'd1);
    chk("miss_c1_bub", 32'(o_bub), 32'd0);
    chk("miss_c1_hs", 32'(o_hs), 32'd1);
    step();
    #1 chk("miss_c2_exec", 32'(o_se), 32'd1);
    chk("miss_c2_count", o_cnt, 32'd1);
    step();
    t_ready = 1; clr_dm(1); set_dm(2, 5, 3'b010); step();
    clr_dm(2); set_dm(3, 5, 3'b010);
    #1 chk("miss_c4_exec", 32'(o_se), 32'd1);
    step();
    clr_dm(3);
    #1 chk("miss_c5_exec", 32'(o_se), 32'd0);
    chk("miss_c5_count", o_cnt, 32'd3);
    step();

    // Reset mid-stall, then a DM3 hazard lasts a single cycle from IDLE.
    do_reset();
    t_rs1 = 5; t_rs1_used = 1; set_dm(1, 5, 3'b010); step();
    t_rst = 1;
    #1 chk("rst_c1_exec", 32'(o_se), 32'd0);
    chk("rst_c1_bub", 32'(o_bub), 32'd0);
    chk("rst_c1_count", o_cnt, 32'd0);
    step();
    t_rst = 0; clear_all();
    #1 chk("rst_c2_exec", 32'(o_se), 32'd0);
    chk("rst_c2_count", o_cnt, 32'd0);
    step();
    t_rs1 = 9; t_rs1_used = 1; set_dm(3, 9, 3'b001);
    #1 chk("rst_c3_hs", 32'(o_hs), 32'd3);
    step();
    clr_dm(3);
    #1 chk("rst_c4_exec", 32'(o_se), 32'd0);
    step();

    // Five single-cycle DM3 stalls wrap the 2-bit counter to 1.
    do_reset();
    t_rs2 = 12; t_rs2_used = 1; set_dm(3, 12, 3'b010);
    for (int i = 0; i < 5; i++) step();
    clear_all();
    #1 chk("wrap_count_w2", 32'(o2_cnt), 32'd1);
    chk("wrap_count", o_cnt, 32'd5);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
